// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserialiser: gathers WIDTH bits into a word and
// hands it to a ready/valid consumer, flagging words lost to back-pressure.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         d_in,
  input  logic                         in_valid,
  input  logic                         clr,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overflow,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Only WIDTH-1 partial bits are ever stored; the final bit goes straight
  // from d_in into the assembled word on the completion edge.
  logic [WIDTH-2:0] shift_reg;
  logic [WIDTH-2:0] shift_adv;
  logic [WIDTH-1:0] word_next;
  logic             complete;
  logic             space;

  generate
    if (MSB_FIRST) begin : g_msb
      assign word_next = {shift_reg, d_in};
      assign shift_adv = word_next[WIDTH-2:0];
    end else begin : g_lsb
      assign word_next = {d_in, shift_reg};
      assign shift_adv = word_next[WIDTH-1:1];
    end
  endgenerate

  assign complete = in_valid && (bit_cnt == LAST);
  assign space    = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (clr) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (in_valid) begin
        if (complete) begin
          shift_reg <= '0;
          bit_cnt   <= '0;
          if (space) begin
            out_data  <= word_next;
            out_valid <= 1'b1;
          end else begin
            overflow  <= 1'b1;
          end
        end else begin
          shift_reg <= shift_adv;
          bit_cnt   <= bit_cnt + CW'(1);
        end
      end
      // A same-edge completion refills the slot, so only a bare accept empties it.
      if (out_valid && out_ready && !complete) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: a vector table for the main flow plus
// hand-written sequences for bit ordering and asynchronous reset.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       d_in;
  logic       in_valid;
  logic       clr;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       overflow;
  logic [3:0] bit_cnt;
  logic [7:0] lsb_data;
  logic       lsb_valid;
  logic       lsb_overflow;
  logic [3:0] lsb_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .d_in(d_in), .in_valid(in_valid), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .bit_cnt(bit_cnt)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .d_in(d_in), .in_valid(in_valid), .clr(clr),
    .out_data(lsb_data), .out_valid(lsb_valid), .out_ready(out_ready),
    .overflow(lsb_overflow), .bit_cnt(lsb_cnt)
  );

  typedef enum int {K_BIT, K_IDLE, K_WORD, K_CLR} kind_t;

  typedef struct {
    kind_t      kind;
    logic [7:0] data;
    logic       valid_in;
    logic       ready;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovf;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(kind_t k, logic [7:0] dat, logic v, logic r,
                              logic [7:0] ed, logic ev, logic eo, logic [3:0] ec);
    vec_t t;
    t.kind = k; t.data = dat; t.valid_in = v; t.ready = r;
    t.exp_data = ed; t.exp_valid = ev; t.exp_ovf = eo; t.exp_cnt = ec;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_edge(input logic d, input logic v, input logic c, input logic r);
    @(negedge clk);
    d_in = d; in_valid = v; clr = c; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic ready_last);
    for (int i = 0; i < 8; i++) begin
      drive_edge(w[7-i], 1'b1, 1'b0, (i == 7) ? ready_last : 1'b0);
    end
  endtask

  initial begin
    reset_n = 1'b0; d_in = 1'b0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    #2;
    check("reset out_data",  {24'd0, out_data}, 32'h00);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset overflow",  {31'd0, overflow}, 32'd0);
    check("reset bit_cnt",   {28'd0, bit_cnt}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // First word 1,0,1,1,0,0,1,0 one bit at a time, with a stall after bit 3.
    vecs.push_back(mk(K_BIT,  8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1));
    vecs.push_back(mk(K_BIT,  8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd2));
    vecs.push_back(mk(K_BIT,  8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3));
    vecs.push_back(mk(K_BIT,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3));
    vecs.push_back(mk(K_BIT,  8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd4));
    vecs.push_back(mk(K_BIT,  8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd5));
    vecs.push_back(mk(K_BIT,  8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd6));
    vecs.push_back(mk(K_BIT,  8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd7));
    vecs.push_back(mk(K_BIT,  8'h00, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 4'd0));
    // Holding without ready, then accept, then ready ignored while empty.
    vecs.push_back(mk(K_IDLE, 8'h00, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b0, 4'd0));
    vecs.push_back(mk(K_IDLE, 8'h00, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 4'd0));
    vecs.push_back(mk(K_IDLE, 8'h00, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 4'd0));
    // Back-pressure: A kept, B dropped with overflow; accept leaves overflow sticky.
    vecs.push_back(mk(K_WORD, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd0));
    vecs.push_back(mk(K_WORD, 8'hA5, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 4'd0));
    vecs.push_back(mk(K_IDLE, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 4'd0));
    // Three bits, then clr alongside a sample and a ready.
    vecs.push_back(mk(K_BIT,  8'h01, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 4'd1));
    vecs.push_back(mk(K_BIT,  8'h01, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 4'd2));
    vecs.push_back(mk(K_BIT,  8'h01, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 4'd3));
    vecs.push_back(mk(K_CLR,  8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 4'd0));
    // Fresh word proves the clr-edge bit was not captured; then accept+complete.
    vecs.push_back(mk(K_WORD, 8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 4'd0));
    vecs.push_back(mk(K_WORD, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 4'd0));
    vecs.push_back(mk(K_IDLE, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 4'd0));

    for (int n = 0; n < vecs.size(); n++) begin
      case (vecs[n].kind)
        K_BIT:   drive_edge(vecs[n].data[0], vecs[n].valid_in, 1'b0, vecs[n].ready);
        K_IDLE:  drive_edge(1'b1, 1'b0, 1'b0, vecs[n].ready);
        K_CLR:   drive_edge(1'b1, vecs[n].valid_in, 1'b1, vecs[n].ready);
        default: send_word(vecs[n].data, vecs[n].ready);
      endcase
      $display("vec %0d kind=%0d data=%02h valid=%0b ovf=%0b cnt=%0d",
               n, vecs[n].kind, out_data, out_valid, overflow, bit_cnt);
      check($sformatf("vec%0d out_data", n),  {24'd0, out_data},  {24'd0, vecs[n].exp_data});
      check($sformatf("vec%0d out_valid", n), {31'd0, out_valid}, {31'd0, vecs[n].exp_valid});
      check($sformatf("vec%0d overflow", n),  {31'd0, overflow},  {31'd0, vecs[n].exp_ovf});
      check($sformatf("vec%0d bit_cnt", n),   {28'd0, bit_cnt},   {28'd0, vecs[n].exp_cnt});
    end

    // Same stream into both bit orders.
    send_word(8'hB2, 1'b0);
    $display("order: msb=%02h lsb=%02h", out_data, lsb_data);
    check("msb_first word", {24'd0, out_data}, 32'hB2);
    check("lsb_first word", {24'd0, lsb_data}, 32'h4D);
    check("lsb_first valid", {31'd0, lsb_valid}, 32'd1);
    drive_edge(1'b0, 1'b0, 1'b0, 1'b1);

    // Five bits, then an asynchronous reset between edges.
    for (int i = 0; i < 5; i++) drive_edge(1'b0, 1'b1, 1'b0, 1'b0);
    check("pre-reset bit_cnt", {28'd0, bit_cnt}, 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    $display("reset: data=%02h valid=%0b ovf=%0b cnt=%0d", out_data, out_valid, overflow, bit_cnt);
    check("async reset bit_cnt",   {28'd0, bit_cnt}, 32'd0);
    check("async reset out_data",  {24'd0, out_data}, 32'h00);
    check("async reset out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("held reset bit_cnt", {28'd0, bit_cnt}, 32'd0);
    @(negedge clk);
    d_in = 1'b1; in_valid = 1'b1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("first edge after reset", {28'd0, bit_cnt}, 32'd1);
    for (int i = 0; i < 7; i++) drive_edge(1'b1, 1'b1, 1'b0, 1'b0);
    $display("after reset word: data=%02h valid=%0b cnt=%0d", out_data, out_valid, bit_cnt);
    check("post-reset word",  {24'd0, out_data}, 32'hFF);
    check("post-reset valid", {31'd0, out_valid}, 32'd1);
    check("post-reset cnt",   {28'd0, bit_cnt}, 32'd0);
    check("post-reset lsb",   {24'd0, lsb_data}, 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
